texture_arbiter: RTL and testbench
==================================

# texture_arbiter

Shares one single-port texture BROM between up to NUM_REQ texture requesters (one per parallel transformation lane) in the raycast pipeline. Each cycle it grants at most one pending read, drives the BROM address and tracks the grant through the BROM read latency. It then returns the texel to the lane that issued the read. Without it, each transformation lane would need its own texture memory copy.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- ADDR_WIDTH, 14: texture BROM address width ({texture id, texY, texX}).
- DATA_WIDTH, 16: texel width, RGB565.
- READ_LATENCY, 2: BROM address-to-data cycles, 1..3.
- pixel_clk_in  in  1  single clock domain.
- rst_in  in  1  synchronous active-high reset.
- req_valid_in  in  NUM_REQ  per-lane read request; held until accepted.
- req_addr_in  in  NUM_REQ*ADDR_WIDTH  lane k address in bits [k*ADDR_WIDTH +: ADDR_WIDTH]; stable while valid.
- req_ready_out  out  NUM_REQ  one-hot grant; handshake = valid & ready.
- resp_valid_out  out  NUM_REQ  one-hot, one-cycle pulse: texel for lane k is on resp_data_out.
- resp_data_out  out  DATA_WIDTH  returned texel; shared by all lanes.
- busy_out  out  1  high while any accepted read is still in flight.
- mem_addr_out  out  ADDR_WIDTH  texture BROM address.
- mem_data_in  in  DATA_WIDTH  texture BROM read data.

## Operation
- Grant logic is combinational from req_valid_in and the priority pointer.
  - req_ready_out is one-hot or zero.
  - req_ready_out is never asserted for a lane whose valid is low.
- Round-robin: search starts at pointer rr_ptr and wraps modulo NUM_REQ. The first valid lane wins.
- After a grant to lane k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
- mem_addr_out = req_addr_in of the granted lane; with no grant it holds its last value.
- Tag pipeline of READ_LATENCY stages. Each stage holds {valid, lane index}.
  - Stage 0 loads the grant.
  - Each stage shifts every cycle.
  - The last stage drives resp_valid_out (decoded one-hot).
- resp_data_out = mem_data_in, passed through combinationally. It is meaningful only when resp_valid_out != 0.
- Requesters must accept responses unconditionally; there is no response backpressure.
- Order: responses return in grant order. A lane may issue back-to-back requests, one per granted cycle.
- busy_out = OR of all tag-stage valid bits.
- Reset values:
  - req_ready_out = 0, resp_valid_out = 0, busy_out = 0.
  - mem_addr_out = 0, rr_ptr = 0.
  - All tag stages invalid.

## Timing
- Handshake on lane k in cycle t → resp_valid_out[k] = 1 in cycle t+READ_LATENCY, with the texel of that address.
- Throughput: one grant per cycle, sustained. There are no bubbles between grants to different lanes.
- Simultaneous requests: exactly one granted per cycle. Losers keep valid high and are granted in later cycles per rr_ptr.
- Starvation bound: a valid lane is granted within NUM_REQ cycles.
- A grant and a response for the same lane may occur in the same cycle. This is legal and independent.
- A valid drop without handshake is a protocol violation; no grant is issued for it. Verification flags it as an assertion error.
- Reset mid-operation:
  - In-flight reads are discarded; no resp_valid_out pulses follow reset.
  - The first grant is possible in the cycle after rst_in falls.
- READ_LATENCY = 1: a single tag stage. Response follows the grant by exactly one cycle.

## Configuration
- TEXTURE_ARBITER_ROUND_ROBIN_EN defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest index wins.
  - rr_ptr is not implemented.
  - The starvation bound does not apply.
  - All other behaviour, including latency, is identical.

## Test plan
- Single lane: lane 0 requests addr 0x0123 with the BROM model returning addr^0xFFFF → req_ready_out = 01 same cycle; resp_valid_out = 01 two cycles later with data 0xFEDC; busy_out high for those two cycles.
- Contention: both lanes request continuously from reset (addrs 0x0010, 0x0020) → grants alternate 01, 10, 01, 10. Responses alternate with data matching each address, each 2 cycles after its grant.
- Back-to-back: lane 1 alone issues addrs 5, 6, 7 in consecutive cycles → three consecutive resp_valid_out = 10 pulses, with data for 5, 6, 7 in order.
- Reset mid-flight: grant lane 0 at cycle t, assert rst_in at t+1 → no resp_valid_out at t+2; all outputs are at reset values; busy_out = 0.
- Fixed priority (macro undefined): both lanes request continuously → lane 0 is granted every cycle; lane 1 is granted only after lane 0 deasserts.
- NUM_REQ = 4, READ_LATENCY = 3, all valid: grants are 0, 1, 2, 3, 0, and each response arrives exactly 3 cycles after its grant.

Source files
------------

// File: rtl/texture_arbiter_if.sv
// Requester/BROM bundle for texture_arbiter.
// The slave modport is the arbiter side; master is the lanes plus texture BROM side.
interface texture_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [NUM_REQ-1:0]            resp_valid_out;
    logic [DATA_WIDTH-1:0]         resp_data_out;
    logic                          busy_out;
    logic [ADDR_WIDTH-1:0]         mem_addr_out;
    logic [DATA_WIDTH-1:0]         mem_data_in;

    modport slave (
        input  req_valid_in,
        input  req_addr_in,
        input  mem_data_in,
        output req_ready_out,
        output resp_valid_out,
        output resp_data_out,
        output busy_out,
        output mem_addr_out
    );

    modport master (
        output req_valid_in,
        output req_addr_in,
        output mem_data_in,
        input  req_ready_out,
        input  resp_valid_out,
        input  resp_data_out,
        input  busy_out,
        input  mem_addr_out
    );
endinterface

// File: rtl/texture_arbiter.sv
// Shares one single-port texture BROM between NUM_REQ raycast lanes, routing texels back by tag.
// TEXTURE_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lane 0 has fixed priority.
module texture_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    texture_arbiter_if.slave tex
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                    grant_any;
    logic [IDX_W-1:0]        grant_idx;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [IDX_W-1:0]        tag_idx [READ_LATENCY];

`ifdef TEXTURE_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rot_valid;

    // Rotate so bit 0 is the lane at rr_ptr, then take the first set bit.
    always_comb begin
        int lane;
        grant_any = 1'b0;
        grant_idx = '0;
        lane      = 0;
        rot_valid = NUM_REQ'({tex.req_valid_in, tex.req_valid_in} >> rr_ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && rot_valid[i]) begin
                lane = int'(rr_ptr) + i;
                if (lane >= NUM_REQ) begin
                    lane = lane - NUM_REQ;
                end
                grant_any = 1'b1;
                grant_idx = IDX_W'(lane);
            end
        end
        if (rst_in) begin
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (tex.req_valid_in[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        if (rst_in) begin
            grant_any = 1'b0;
        end
    end
`endif

    always_comb begin
        grant_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                grant_addr = tex.req_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Tag pipeline mirrors the BROM latency so the last stage lines up with mem_data_in.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            addr_q    <= '0;
            tag_valid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            if (grant_any) begin
                addr_q <= grant_addr;
            end
            tag_valid[0] <= grant_any;
            tag_idx[0]   <= grant_idx;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_idx[s]   <= tag_idx[s-1];
            end
        end
    end

    always_comb begin
        tex.req_ready_out = '0;
        if (grant_any) begin
            tex.req_ready_out[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        tex.resp_valid_out = '0;
        if (tag_valid[READ_LATENCY-1]) begin
            tex.resp_valid_out[tag_idx[READ_LATENCY-1]] = 1'b1;
        end
    end

    // Address goes out combinationally on the grant cycle so the BROM latency starts immediately.
    assign tex.mem_addr_out  = grant_any ? grant_addr : addr_q;
    assign tex.resp_data_out = tex.mem_data_in;
    assign tex.busy_out      = |tag_valid;
endmodule

// File: tb/tb_texture_arbiter.sv
// Directed bench for texture_arbiter: 2 lanes/latency 2, 4 lanes/latency 3, 2 lanes/latency 1.
// BROM models return the zero-extended address XOR 0xFFFF after each instance's latency.
module tb_texture_arbiter;
    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_step = 0;
    logic [13:0] lane_addr [4];
    logic [3:0]  v1, v2, v3;

    always #5 pixel_clk_in = ~pixel_clk_in;

    texture_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(14), .DATA_WIDTH(16)) if2 ();
    texture_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(14), .DATA_WIDTH(16)) if4 ();
    texture_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(14), .DATA_WIDTH(16)) if1 ();

    texture_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(14), .DATA_WIDTH(16), .READ_LATENCY(2)) u_dut2 (
        .pixel_clk_in(pixel_clk_in), .rst_in(rst_in), .tex(if2));
    texture_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(14), .DATA_WIDTH(16), .READ_LATENCY(3)) u_dut4 (
        .pixel_clk_in(pixel_clk_in), .rst_in(rst_in), .tex(if4));
    texture_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(14), .DATA_WIDTH(16), .READ_LATENCY(1)) u_dut1 (
        .pixel_clk_in(pixel_clk_in), .rst_in(rst_in), .tex(if1));

    logic [13:0] rom2 [2];
    logic [13:0] rom4 [3];
    logic [13:0] rom1;

    always_ff @(posedge pixel_clk_in) begin
        rom2[0] <= if2.mem_addr_out;
        rom2[1] <= rom2[0];
        rom4[0] <= if4.mem_addr_out;
        rom4[1] <= rom4[0];
        rom4[2] <= rom4[1];
        rom1    <= if1.mem_addr_out;
    end

    assign if2.mem_data_in = {2'b00, rom2[1]} ^ 16'hFFFF;
    assign if4.mem_data_in = {2'b00, rom4[2]} ^ 16'hFFFF;
    assign if1.mem_data_in = {2'b00, rom1} ^ 16'hFFFF;

    // A waiting lane must keep valid high until it is granted.
    for (genvar k = 0; k < 2; k++) begin : g_hold2
        a_hold: assert property (@(posedge pixel_clk_in) disable iff (rst_in)
            (if2.req_valid_in[k] && !if2.req_ready_out[k]) |=> if2.req_valid_in[k]);
    end
    for (genvar k = 0; k < 4; k++) begin : g_hold4
        a_hold: assert property (@(posedge pixel_clk_in) disable iff (rst_in)
            (if4.req_valid_in[k] && !if4.req_ready_out[k]) |=> if4.req_valid_in[k]);
    end
    for (genvar k = 0; k < 2; k++) begin : g_hold1
        a_hold: assert property (@(posedge pixel_clk_in) disable iff (rst_in)
            (if1.req_valid_in[k] && !if1.req_ready_out[k]) |=> if1.req_valid_in[k]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the selected instance, check its outputs at the falling edge.
    task automatic step(input int sel, input logic rst, input logic [3:0] v,
                        input logic [3:0] rdy, input logic [3:0] rsp, input logic [15:0] dat,
                        input logic bsy, input logic [13:0] madr);
        logic [3:0]  o_rdy;
        logic [3:0]  o_rsp;
        logic [15:0] o_dat;
        logic        o_bsy;
        logic [13:0] o_madr;
        rst_in           = rst;
        if2.req_valid_in = (sel == 2) ? v[1:0] : 2'b00;
        if4.req_valid_in = (sel == 4) ? v : 4'b0000;
        if1.req_valid_in = (sel == 1) ? v[1:0] : 2'b00;
        if2.req_addr_in  = {lane_addr[1], lane_addr[0]};
        if1.req_addr_in  = {lane_addr[1], lane_addr[0]};
        if4.req_addr_in  = {lane_addr[3], lane_addr[2], lane_addr[1], lane_addr[0]};
        @(negedge pixel_clk_in);
        case (sel)
            2: begin
                o_rdy  = {2'b00, if2.req_ready_out};
                o_rsp  = {2'b00, if2.resp_valid_out};
                o_dat  = if2.resp_data_out;
                o_bsy  = if2.busy_out;
                o_madr = if2.mem_addr_out;
            end
            4: begin
                o_rdy  = if4.req_ready_out;
                o_rsp  = if4.resp_valid_out;
                o_dat  = if4.resp_data_out;
                o_bsy  = if4.busy_out;
                o_madr = if4.mem_addr_out;
            end
            default: begin
                o_rdy  = {2'b00, if1.req_ready_out};
                o_rsp  = {2'b00, if1.resp_valid_out};
                o_dat  = if1.resp_data_out;
                o_bsy  = if1.busy_out;
                o_madr = if1.mem_addr_out;
            end
        endcase
        chk($sformatf("step%0d ready", n_step), 32'(o_rdy), 32'(rdy));
        chk($sformatf("step%0d resp_valid", n_step), 32'(o_rsp), 32'(rsp));
        if (rsp != 4'h0) begin
            chk($sformatf("step%0d resp_data", n_step), 32'(o_dat), 32'(dat));
        end
        chk($sformatf("step%0d busy", n_step), 32'(o_bsy), 32'(bsy));
        chk($sformatf("step%0d mem_addr", n_step), 32'(o_madr), 32'(madr));
        n_step++;
        @(posedge pixel_clk_in);
        #1;
    endtask

    initial begin
        rst_in           = 1'b1;
        if2.req_valid_in = '0;
        if4.req_valid_in = '0;
        if1.req_valid_in = '0;
        if2.req_addr_in  = '0;
        if4.req_addr_in  = '0;
        if1.req_addr_in  = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = '0;
        end
        repeat (2) @(posedge pixel_clk_in);
        #1;

        // Single lane 0 read, then reset values.
        lane_addr[0] = 14'h0123;
        step(2, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0000);
        step(2, 1'b0, 4'h1, 4'h1, 4'h0, 16'h0000, 1'b0, 14'h0123);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 14'h0123);
        step(2, 1'b0, 4'h0, 4'h0, 4'h1, 16'hFEDC, 1'b1, 14'h0123);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0123);

        // Lane 1 back-to-back 5, 6, 7; grant and response overlap on lane 1.
        lane_addr[1] = 14'h0005;
        step(2, 1'b0, 4'h2, 4'h2, 4'h0, 16'h0000, 1'b0, 14'h0005);
        lane_addr[1] = 14'h0006;
        step(2, 1'b0, 4'h2, 4'h2, 4'h0, 16'h0000, 1'b1, 14'h0006);
        lane_addr[1] = 14'h0007;
        step(2, 1'b0, 4'h2, 4'h2, 4'h2, 16'hFFFA, 1'b1, 14'h0007);
        step(2, 1'b0, 4'h0, 4'h0, 4'h2, 16'hFFF9, 1'b1, 14'h0007);
        step(2, 1'b0, 4'h0, 4'h0, 4'h2, 16'hFFF8, 1'b1, 14'h0007);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0007);

        // Contention from reset.
        lane_addr[0] = 14'h0010;
        lane_addr[1] = 14'h0020;
        step(2, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0007);
`ifdef TEXTURE_ARBITER_ROUND_ROBIN_EN
        step(2, 1'b0, 4'h3, 4'h1, 4'h0, 16'h0000, 1'b0, 14'h0010);
        step(2, 1'b0, 4'h3, 4'h2, 4'h0, 16'h0000, 1'b1, 14'h0020);
        step(2, 1'b0, 4'h3, 4'h1, 4'h1, 16'hFFEF, 1'b1, 14'h0010);
        step(2, 1'b0, 4'h3, 4'h2, 4'h2, 16'hFFDF, 1'b1, 14'h0020);
        step(2, 1'b0, 4'h1, 4'h1, 4'h1, 16'hFFEF, 1'b1, 14'h0010);
        step(2, 1'b0, 4'h0, 4'h0, 4'h2, 16'hFFDF, 1'b1, 14'h0010);
        step(2, 1'b0, 4'h0, 4'h0, 4'h1, 16'hFFEF, 1'b1, 14'h0010);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0010);
`else
        step(2, 1'b0, 4'h3, 4'h1, 4'h0, 16'h0000, 1'b0, 14'h0010);
        step(2, 1'b0, 4'h3, 4'h1, 4'h0, 16'h0000, 1'b1, 14'h0010);
        step(2, 1'b0, 4'h3, 4'h1, 4'h1, 16'hFFEF, 1'b1, 14'h0010);
        step(2, 1'b0, 4'h2, 4'h2, 4'h1, 16'hFFEF, 1'b1, 14'h0020);
        step(2, 1'b0, 4'h0, 4'h0, 4'h1, 16'hFFEF, 1'b1, 14'h0020);
        step(2, 1'b0, 4'h0, 4'h0, 4'h2, 16'hFFDF, 1'b1, 14'h0020);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0020);
`endif

        // Reset one cycle after a grant: the read is dropped.
        lane_addr[0] = 14'h0040;
        step(2, 1'b0, 4'h1, 4'h1, 4'h0, 16'h0000, 1'b0, 14'h0040);
        step(2, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 14'h0040);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0000);
        step(2, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0000);

        // Four lanes, latency 3: grants 0,1,2,3,0.
        lane_addr[0] = 14'h0100;
        lane_addr[1] = 14'h0200;
        lane_addr[2] = 14'h0300;
        lane_addr[3] = 14'h0400;
`ifdef TEXTURE_ARBITER_ROUND_ROBIN_EN
        v1 = 4'hF;
        v2 = 4'hD;
        v3 = 4'h9;
`else
        v1 = 4'hE;
        v2 = 4'hC;
        v3 = 4'h8;
`endif
        step(4, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0000);
        step(4, 1'b0, 4'hF, 4'h1, 4'h0, 16'h0000, 1'b0, 14'h0100);
        step(4, 1'b0, v1,   4'h2, 4'h0, 16'h0000, 1'b1, 14'h0200);
        step(4, 1'b0, v2,   4'h4, 4'h0, 16'h0000, 1'b1, 14'h0300);
        step(4, 1'b0, v3,   4'h8, 4'h1, 16'hFEFF, 1'b1, 14'h0400);
        step(4, 1'b0, 4'h1, 4'h1, 4'h2, 16'hFDFF, 1'b1, 14'h0100);
        step(4, 1'b0, 4'h0, 4'h0, 4'h4, 16'hFCFF, 1'b1, 14'h0100);
        step(4, 1'b0, 4'h0, 4'h0, 4'h8, 16'hFBFF, 1'b1, 14'h0100);
        step(4, 1'b0, 4'h0, 4'h0, 4'h1, 16'hFEFF, 1'b1, 14'h0100);
        step(4, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0100);

        // Latency 1: response one cycle after each grant.
        lane_addr[0] = 14'h00AA;
        lane_addr[1] = 14'h0055;
        step(1, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0000);
        step(1, 1'b0, 4'h1, 4'h1, 4'h0, 16'h0000, 1'b0, 14'h00AA);
        step(1, 1'b0, 4'h2, 4'h2, 4'h1, 16'hFF55, 1'b1, 14'h0055);
        step(1, 1'b0, 4'h0, 4'h0, 4'h2, 16'hFFAA, 1'b1, 14'h0055);
        step(1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 14'h0055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
